wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 47 ++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: writeback widths, scalar/vector entry types and requester-select enum
package wb_pkg;
    localparam int ADDR_W  = 5;
    localparam int SDATA_W = 36;
    localparam int VDATA_W = 128;
    localparam int MASK_W  = 4;
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [SDATA_W-1:0] data;
    } s_entry_t;
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [VDATA_W-1:0] data;
        logic [MASK_W-1:0]  mask;
    } v_entry_t;
    typedef enum logic {
        REQ_SCALAR = 1'b0,
        REQ_VECTOR = 1'b1
    } req_sel_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO with sync flush; in push/pop/din/flush, out full/empty/head
module wb_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];
    always_comb begin
        do_push = push & ~full & ~flush;
        do_pop  = pop & ~empty & ~flush;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = flush ? '0 : wr_q + PW'(do_push);
        rd_d  = flush ? '0 : rd_q + PW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: four writeback queues, round-robin per RF port, registered rf/vrf write ports, stalls, sticky overflow
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               s_wb_valid,
    input  logic [ADDR_W-1:0]  s_wb_addr,
    input  logic [SDATA_W-1:0] s_wb_data,
    input  logic               v_wb_valid,
    input  logic [ADDR_W-1:0]  v_wb_addr,
    input  logic [SDATA_W-1:0] v_wb_data,
    input  logic               s_vwb_valid,
    input  logic [ADDR_W-1:0]  s_vwb_addr,
    input  logic [VDATA_W-1:0] s_vwb_data,
    input  logic [MASK_W-1:0]  s_vwb_mask,
    input  logic               v_vwb_valid,
    input  logic [ADDR_W-1:0]  v_vwb_addr,
    input  logic [VDATA_W-1:0] v_vwb_data,
    input  logic [MASK_W-1:0]  v_vwb_mask,
    output logic               s_stall,
    output logic               v_stall,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_addr,
    output logic [SDATA_W-1:0] rf_data,
    output logic               vrf_we,
    output logic [ADDR_W-1:0]  vrf_addr,
    output logic [VDATA_W-1:0] vrf_data,
    output logic [MASK_W-1:0]  vrf_mask,
    output logic               overflow
);
    s_entry_t  sqs_head, sqv_head, rf_q, rf_d;
    v_entry_t  vqs_head, vqv_head, vrf_q, vrf_d;
    logic      sqs_full, sqv_full, vqs_full, vqv_full;
    logic      sqs_empty, sqv_empty, vqs_empty, vqv_empty;
    logic      sqs_pop, sqv_pop, vqs_pop, vqv_pop;
    logic      rf_we_q, rf_we_d, vrf_we_q, vrf_we_d, overflow_q, overflow_d;
    req_sel_e  srr_q, srr_d, vrr_q, vrr_d;
    wb_fifo #(.T(s_entry_t), .DEPTH(DEPTH)) u_sq_s (
        .clk(clk), .rst(rst), .flush(flush), .push(s_wb_valid), .pop(sqs_pop),
        .din({s_wb_addr, s_wb_data}), .full(sqs_full), .empty(sqs_empty), .head(sqs_head)
    );
    wb_fifo #(.T(s_entry_t), .DEPTH(DEPTH)) u_sq_v (
        .clk(clk), .rst(rst), .flush(flush), .push(v_wb_valid), .pop(sqv_pop),
        .din({v_wb_addr, v_wb_data}), .full(sqv_full), .empty(sqv_empty), .head(sqv_head)
    );
    wb_fifo #(.T(v_entry_t), .DEPTH(DEPTH)) u_vq_s (
        .clk(clk), .rst(rst), .flush(flush), .push(s_vwb_valid), .pop(vqs_pop),
        .din({s_vwb_addr, s_vwb_data, s_vwb_mask}), .full(vqs_full), .empty(vqs_empty), .head(vqs_head)
    );
    wb_fifo #(.T(v_entry_t), .DEPTH(DEPTH)) u_vq_v (
        .clk(clk), .rst(rst), .flush(flush), .push(v_vwb_valid), .pop(vqv_pop),
        .din({v_vwb_addr, v_vwb_data, v_vwb_mask}), .full(vqv_full), .empty(vqv_empty), .head(vqv_head)
    );
    assign s_stall  = sqs_full | vqs_full;
    assign v_stall  = sqv_full | vqv_full;
    assign rf_we    = rf_we_q;
    assign rf_addr  = rf_q.addr;
    assign rf_data  = rf_q.data;
    assign vrf_we   = vrf_we_q;
    assign vrf_addr = vrf_q.addr;
    assign vrf_data = vrf_q.data;
    assign vrf_mask = vrf_q.mask;
    assign overflow = overflow_q;
    // A lone non-empty head wins outright; on contention rr decides, then points at the loser.
    always_comb begin
        sqs_pop    = ~flush & ~sqs_empty & (sqv_empty | srr_q == REQ_SCALAR);
        sqv_pop    = ~flush & ~sqv_empty & (sqs_empty | srr_q == REQ_VECTOR);
        vqs_pop    = ~flush & ~vqs_empty & (vqv_empty | vrr_q == REQ_SCALAR);
        vqv_pop    = ~flush & ~vqv_empty & (vqs_empty | vrr_q == REQ_VECTOR);
        srr_d      = sqs_pop ? REQ_VECTOR : sqv_pop ? REQ_SCALAR : srr_q;
        vrr_d      = vqs_pop ? REQ_VECTOR : vqv_pop ? REQ_SCALAR : vrr_q;
        rf_we_d    = sqs_pop | sqv_pop;
        vrf_we_d   = vqs_pop | vqv_pop;
        rf_d       = sqs_pop ? sqs_head : sqv_pop ? sqv_head : rf_q;
        vrf_d      = vqs_pop ? vqs_head : vqv_pop ? vqv_head : vrf_q;
        overflow_d = overflow_q | (~flush & ((s_wb_valid & sqs_full) | (v_wb_valid & sqv_full) |
                                             (s_vwb_valid & vqs_full) | (v_vwb_valid & vqv_full)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srr_q      <= REQ_SCALAR;
            vrr_q      <= REQ_SCALAR;
            rf_we_q    <= 1'b0;
            vrf_we_q   <= 1'b0;
            rf_q       <= '0;
            vrf_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            srr_q      <= srr_d;
            vrr_q      <= vrr_d;
            rf_we_q    <= rf_we_d;
            vrf_we_q   <= vrf_we_d;
            rf_q       <= rf_d;
            vrf_q      <= vrf_d;
            overflow_q <= overflow_d;
        end
    end
endmodule
